// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU among
// NREQ requesters and returns each result through a one-deep response register.
// Optional build define ALU_ARB_OPCHECK_EN: illegal opcodes are still consumed
// but return a zero result with rsp_err_o set.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    input  logic [NREQ*4-1:0] req_op_i,
    output logic [W-1:0]      alu_a_o,
    output logic [W-1:0]      alu_b_o,
    output logic [3:0]        alu_op_o,
    input  logic [W-1:0]      alu_c_i,
    input  logic              alu_flag_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [1:0]        rsp_id_o,
    output logic [W-1:0]      rsp_c_o,
    output logic              rsp_flag_o,
    output logic              rsp_err_o
);

    localparam logic [2:0] NREQ3 = 3'(NREQ);
    localparam logic [1:0] LAST  = 2'(NREQ - 1);

    logic [1:0]   ptr_q, ptr_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0] rsp_c_q, rsp_c_d;
    logic         rsp_flag_q, rsp_flag_d;
    logic         rsp_err_q, rsp_err_d;

    logic         win_found;
    logic [1:0]   win_idx;
    logic [2:0]   cand;
    logic         free;
    logic         accept;

`ifdef ALU_ARB_OPCHECK_EN
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8, 4'hB: op_legal = 1'b1;
            default:                      op_legal = 1'b0;
        endcase
    endfunction
`endif

    // Search valid requests starting at the round-robin pointer; nothing wins during reset.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= NREQ3) begin
                cand = cand - NREQ3;
            end
            if (rstn_i && !win_found && req_valid_i[cand[1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end

    // Steer the winner's operands to the shared ALU whether or not the slot is free.
    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = 4'b0000;
        if (win_found) begin
            alu_a_o  = req_a_i[int'(win_idx)*W +: W];
            alu_b_o  = req_b_i[int'(win_idx)*W +: W];
            alu_op_o = req_op_i[int'(win_idx)*4 +: 4];
        end
    end

    assign free   = !rsp_valid_q || rsp_ready_i;
    assign accept = win_found && free;

    // Grant only the winner, and only when the response slot can take its result.
    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    // Response register and pointer next state: capture on accept, drain when consumed.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        rsp_flag_d  = rsp_flag_q;
        rsp_err_d   = rsp_err_q;
        ptr_d       = ptr_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_idx;
            rsp_c_d     = alu_c_i;
            rsp_flag_d  = alu_flag_i;
            rsp_err_d   = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            if (!op_legal(alu_op_o)) begin
                rsp_c_d    = '0;
                rsp_flag_d = 1'b0;
                rsp_err_d  = 1'b1;
            end
`endif
            if (win_idx == LAST) begin
                ptr_d = 2'd0;
            end else begin
                ptr_d = win_idx + 2'd1;
            end
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State register; reset discards any pending response and rewinds the pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 2'd0;
            rsp_c_q     <= '0;
            rsp_flag_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_flag_q  <= rsp_flag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_c_o     = rsp_c_q;
    assign rsp_flag_o  = rsp_flag_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with NREQ=2 and a reference ALU.
module tb_alu_arbiter;

    localparam int NREQ = 2;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ*32-1:0] req_a_i;
    logic [NREQ*32-1:0] req_b_i;
    logic [NREQ*4-1:0] req_op_i;
    logic [31:0]       alu_a_o;
    logic [31:0]       alu_b_o;
    logic [3:0]        alu_op_o;
    logic [31:0]       alu_c_i;
    logic              alu_flag_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [1:0]        rsp_id_o;
    logic [31:0]       rsp_c_o;
    logic              rsp_flag_o;
    logic              rsp_err_o;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] c;
        logic        flag;
        logic        err;
    } rsp_t;

    rsp_t expQ[$];
    rsp_t lastRsp;
    int   checks = 0;
    int   passes = 0;

    alu_arbiter #(.NREQ(NREQ), .W(32)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_op_i    (req_op_i),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_op_o    (alu_op_o),
        .alu_c_i     (alu_c_i),
        .alu_flag_i  (alu_flag_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_c_o     (rsp_c_o),
        .rsp_flag_o  (rsp_flag_o),
        .rsp_err_o   (rsp_err_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Reference ALU: flag reports a nonzero result, unknown opcodes return 0.
    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a << b[4:0];
            4'h3:    return {31'd0, (a < b)};
            4'hB:    return {31'd0, ($signed(a) < $signed(b))};
            4'h4:    return a ^ b;
            4'h5:    return a >> b[4:0];
            4'h6:    return $unsigned($signed(a) >>> b[4:0]);
            4'h7:    return a | b;
            4'h8:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb begin
        alu_c_i    = refAlu(alu_op_o, alu_a_o, alu_b_o);
        alu_flag_i = |alu_c_i;
    end

`ifdef ALU_ARB_OPCHECK_EN
    function automatic logic isLegal(input logic [3:0] op);
        return (op <= 4'h8) || (op == 4'hB);
    endfunction
`endif

    function automatic rsp_t expRsp(input logic [1:0] id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.id   = id;
        r.c    = refAlu(op, a, b);
        r.flag = |r.c;
        r.err  = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
        if (!isLegal(op)) begin
            r.c    = 32'd0;
            r.flag = 1'b0;
            r.err  = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setReq(input int i, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_valid_i[i]     = v;
        req_a_i[i*32 +: 32] = a;
        req_b_i[i*32 +: 32] = b;
        req_op_i[i*4 +: 4]  = op;
    endtask

    task automatic popExp(output rsp_t e);
        if (expQ.size() != 0) e = expQ.pop_front();
        else e = '1;
    endtask

    task automatic doReset();
        rstn_i      = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = 1'b0;
        tick();
        tick();
        rstn_i = 1'b1;
        expQ.delete();
    endtask

    task automatic test_reset();
        rstn_i      = 1'b0;
        rsp_ready_i = 1'b1;
        setReq(0, 1'b1, 32'h1234, 32'h5678, 4'h0);
        setReq(1, 1'b1, 32'h9ABC, 32'hDEF0, 4'h4);
        tick();
        checks++;
        if (req_ready_o !== 2'b00) $display("[TB] FAIL reset_ready got=%b want=00", req_ready_o);
        else passes++;
        checks++;
        if ({alu_a_o, alu_b_o, alu_op_o} !== 68'd0) $display("[TB] FAIL reset_alu got=%h/%h/%h want=0/0/0", alu_a_o, alu_b_o, alu_op_o);
        else passes++;
        checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== 37'd0)
            $display("[TB] FAIL reset_rsp got=%b/%h/%h/%b/%b want=all zero", rsp_valid_o, rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o);
        else passes++;
        req_valid_i = '0;
        rsp_ready_i = 1'b0;
        tick();
        rstn_i = 1'b1;
    endtask

    task automatic test_single();
        rsp_t e;
        rsp_ready_i = 1'b1;
        setReq(0, 1'b1, 32'd5, 32'd3, 4'h1);
        req_valid_i[1] = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) $display("[TB] FAIL single_ready got=%b want=01", req_ready_o);
        else passes++;
        checks++;
        if (alu_a_o !== 32'd5 || alu_b_o !== 32'd3 || alu_op_o !== 4'h1)
            $display("[TB] FAIL single_alu got=%h/%h/%h want=5/3/1", alu_a_o, alu_b_o, alu_op_o);
        else passes++;
        expQ.push_back('{id: 2'd0, c: 32'd2, flag: 1'b1, err: 1'b0});
        tick();
        req_valid_i = '0;
        popExp(e);
        checks++;
        if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== e)
            $display("[TB] FAIL single_rsp got=%b/%h want=1/%h", rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, e);
        else passes++;
        tick();
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_c_o !== 32'd2)
            $display("[TB] FAIL single_drain got=%b/%h want=0/2", rsp_valid_o, rsp_c_o);
        else passes++;
    endtask

    task automatic test_round_robin();
        rsp_t e;
        int   w;
        doReset();
        rsp_ready_i = 1'b1;
        setReq(0, 1'b1, 32'd100, 32'd7, 4'h0);
        setReq(1, 1'b1, 32'hF0F0_0000, 32'h0FF0_00FF, 4'h4);
        #1;
        for (int k = 0; k < 6; k++) begin
            w = k % 2;
            checks++;
            if (req_ready_o !== (2'b01 << w)) $display("[TB] FAIL rr_grant%0d got=%b want=%b", k, req_ready_o, 2'b01 << w);
            else passes++;
            expQ.push_back(expRsp(2'(w), req_op_i[w*4 +: 4], req_a_i[w*32 +: 32], req_b_i[w*32 +: 32]));
            tick();
            popExp(e);
            checks++;
            if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== e)
                $display("[TB] FAIL rr_rsp%0d got=%b/%h want=1/%h", k, rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, e);
            else passes++;
            lastRsp = e;
            setReq(w, 1'b1, req_a_i[w*32 +: 32] + 32'd11, req_b_i[w*32 +: 32] ^ 32'h3, req_op_i[w*4 +: 4]);
            #1;
        end
        req_valid_i = '0;
    endtask

    task automatic test_backpressure();
        rsp_t e;
        rsp_ready_i = 1'b0;
        setReq(0, 1'b1, 32'd20, 32'd22, 4'h0);
        req_valid_i[1] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready_o !== 2'b00) $display("[TB] FAIL bp_ready%0d got=%b want=00", k, req_ready_o);
            else passes++;
            checks++;
            if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== lastRsp)
                $display("[TB] FAIL bp_hold%0d got=%b/%h want=1/%h", k, rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, lastRsp);
            else passes++;
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) $display("[TB] FAIL bp_release got=%b want=01", req_ready_o);
        else passes++;
        expQ.push_back('{id: 2'd0, c: 32'd42, flag: 1'b1, err: 1'b0});
        tick();
        req_valid_i = '0;
        popExp(e);
        checks++;
        if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== e)
            $display("[TB] FAIL bp_rsp got=%b/%h want=1/%h", rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, e);
        else passes++;
    endtask

    task automatic test_signed_compare();
        rsp_t e;
        rsp_ready_i = 1'b1;
        setReq(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'hB);
        req_valid_i[0] = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 2'b10) $display("[TB] FAIL slt_ready got=%b want=10", req_ready_o);
        else passes++;
        expQ.push_back('{id: 2'd1, c: 32'd1, flag: 1'b1, err: 1'b0});
        tick();
        popExp(e);
        checks++;
        if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== e)
            $display("[TB] FAIL slt_rsp got=%b/%h want=1/%h", rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, e);
        else passes++;
        setReq(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'h3);
        expQ.push_back('{id: 2'd1, c: 32'd0, flag: 1'b0, err: 1'b0});
        tick();
        req_valid_i = '0;
        popExp(e);
        checks++;
        if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== e)
            $display("[TB] FAIL sltu_rsp got=%b/%h want=1/%h", rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, e);
        else passes++;
    endtask

    task automatic test_illegal_op();
        rsp_t e;
        rsp_ready_i = 1'b1;
        setReq(0, 1'b1, 32'd7, 32'd9, 4'hD);
        #1;
        checks++;
        if (req_ready_o !== 2'b01) $display("[TB] FAIL illegal_ready got=%b want=01", req_ready_o);
        else passes++;
`ifdef ALU_ARB_OPCHECK_EN
        expQ.push_back('{id: 2'd0, c: 32'd0, flag: 1'b0, err: 1'b1});
`else
        expQ.push_back('{id: 2'd0, c: 32'd0, flag: 1'b0, err: 1'b0});
`endif
        tick();
        req_valid_i = '0;
        popExp(e);
        checks++;
        if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== e)
            $display("[TB] FAIL illegal_rsp got=%b/%h want=1/%h", rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, e);
        else passes++;
    endtask

    task automatic test_reset_midstream();
        rsp_t e;
        rsp_ready_i = 1'b1;
        setReq(0, 1'b1, 32'd40, 32'd2, 4'h0);
        req_valid_i[1] = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) $display("[TB] FAIL mid_pre_ready got=%b want=01", req_ready_o);
        else passes++;
        expQ.push_back(expRsp(2'd0, 4'h0, 32'd40, 32'd2));
        tick();
        popExp(e);
        checks++;
        if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== e)
            $display("[TB] FAIL mid_pre_rsp got=%b/%h want=1/%h", rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, e);
        else passes++;
        rsp_ready_i = 1'b0;
        setReq(1, 1'b1, 32'h00FF_0000, 32'h0000_00FF, 4'h7);
        #1;
        rstn_i      = 1'b0;
        rsp_ready_i = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_c_o !== 32'd0) $display("[TB] FAIL mid_async_clear got=%b/%h want=0/0", rsp_valid_o, rsp_c_o);
        else passes++;
        checks++;
        if (req_ready_o !== 2'b00) $display("[TB] FAIL mid_ready_in_reset got=%b want=00", req_ready_o);
        else passes++;
        tick();
        rstn_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) $display("[TB] FAIL mid_first_grant got=%b want=01", req_ready_o);
        else passes++;
        expQ.push_back(expRsp(2'd0, 4'h0, 32'd40, 32'd2));
        tick();
        req_valid_i = '0;
        popExp(e);
        checks++;
        if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o} !== e)
            $display("[TB] FAIL mid_post_rsp got=%b/%h want=1/%h", rsp_valid_o, {rsp_id_o, rsp_c_o, rsp_flag_o, rsp_err_o}, e);
        else passes++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_op_i    = '0;
        rsp_ready_i = 1'b0;
        rstn_i      = 1'b0;
        lastRsp     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_signed_compare();
        test_illegal_op();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter sharing one combinational ALU (32-bit operands, 4-bit opcode, result plus flag) among `NREQ` requesters. Each requester uses a valid/ready handshake. The block drives the ALU operand and opcode ports from the winning requester, captures the ALU result in a one-deep output register, and returns it with the winner's index over a valid/ready response channel. It sits between the execute-side issue logic (integer pipe, branch compare, address generation) and the single shared ALU instance.

## Interface
- `NREQ`, 2, number of requesters; legal range 2..4.
- `W`, 32, operand/result width; fixed at 32 by the ALU.
- `clk_i` in 1: single clock, all state updates on the rising edge.
- `rstn_i` in 1: asynchronous, active-low reset.
- `req_valid_i` in NREQ: request valid, one bit per requester.
- `req_ready_o` out NREQ: request accepted this cycle, one-hot or zero.
- `req_a_i` in NREQ*32: operand A; requester i occupies bits [32i+31:32i].
- `req_b_i` in NREQ*32: operand B; same packing as `req_a_i`.
- `req_op_i` in NREQ*4: opcode; requester i occupies bits [4i+3:4i].
- `alu_a_o` out 32: operand A to the ALU.
- `alu_b_o` out 32: operand B to the ALU.
- `alu_op_o` out 4: opcode to the ALU.
- `alu_c_i` in 32: ALU result (combinational from the `alu_*_o` ports).
- `alu_flag_i` in 1: ALU flag (combinational).
- `rsp_valid_o` out 1: response register holds a result.
- `rsp_ready_i` in 1: consumer accepts the response.
- `rsp_id_o` out 2: index of the requester that owns the response.
- `rsp_c_o` out 32: registered result.
- `rsp_flag_o` out 1: registered flag.
- `rsp_err_o` out 1: illegal opcode indication (see Configuration).

## Operation
- Slot free condition: `free = !rsp_valid_o || rsp_ready_i`.
- Arbitration: round-robin pointer `ptr` (0..NREQ-1).
  - Search `req_valid_i` starting at `ptr`, wrapping modulo NREQ; the first set bit wins.
  - `req_ready_o[win] = free`. All other ready bits are 0.
- ALU drive:
  - When a winner exists, `alu_a_o`/`alu_b_o`/`alu_op_o` carry the winner's fields, independent of `free`.
  - With no valid request, they drive 0/0/4'b0000.
- Accept (winner valid and `free`):
  - Capture `alu_c_i`, `alu_flag_i`, and the winner index into the response register.
  - Set `rsp_valid_o`.
  - Set `ptr = (win+1) mod NREQ`.
- No accept with `rsp_ready_i=1`: clear `rsp_valid_o`. Data fields hold their last values.
- `ptr` changes only on accept.
  - A requester waits at most NREQ-1 grants while it holds valid.
- Requesters must hold fields stable while valid and not ready. Deasserting valid before ready is permitted; the request is withdrawn.
- Legal opcodes: 0x0 add, 0x1 sub, 0x2 sll, 0x3 sltu, 0xB slt, 0x4 xor, 0x5 srl, 0x6 sra, 0x7 or, 0x8 and. All others are illegal.

## Timing
- Reset values: `rsp_valid_o=0`, `rsp_c_o=0`, `rsp_flag_o=0`, `rsp_id_o=0`, `rsp_err_o=0`, `ptr=0`.
  - `req_ready_o` and `alu_*_o` are combinational and evaluate to 0 while reset is asserted.
- Latency: 1 cycle. A request accepted in cycle n produces `rsp_valid_o=1` in cycle n+1.
- Throughput: one op/cycle while `rsp_ready_i=1`. A response consumed in cycle n frees the slot for a new accept in the same cycle n, so there are no bubbles.
- Backpressure: if `rsp_valid_o=1` and `rsp_ready_i=0`:
  - all `req_ready_o=0`;
  - the response register holds;
  - `ptr` holds.
- Combinational paths:
  - `req_valid_i`/`rsp_ready_i` → `req_ready_o`.
  - `req_*_i` → `alu_*_o`.
  - `alu_*_i` → response register D input.
  - There is no combinational path from `req_*` to `rsp_*`.
- Reset asserted mid-operation: the pending response is discarded and `ptr` returns to 0. No requester sees ready while `rstn_i=0`.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined: on accept of an illegal opcode, capture `rsp_c_o=0`, `rsp_flag_o=0`, `rsp_err_o=1`.
  - The request is still consumed and `ptr` still advances.
  - Legal opcodes capture `rsp_err_o=0`.
- Not defined: `rsp_err_o` is tied to 0. Illegal opcodes capture whatever the ALU returns, which is 0/0 from its default branch.

## Test plan
- Single request: after reset, req0 presents a=5, b=3, op=0x1 with `rsp_ready_i=1`.
  - `req_ready_o=01` in cycle 0.
  - Cycle 1: `rsp_valid_o=1`, `rsp_c_o=2`, `rsp_id_o=0`.
- Round-robin fairness: NREQ=2, both requesters valid continuously, req0 op=0x0, req1 op=0x4, `rsp_ready_i=1`.
  - Grants alternate 0,1,0,1.
  - One response per cycle with matching `rsp_id_o`.
- Backpressure: response pending, `rsp_ready_i=0` for 3 cycles.
  - `req_ready_o=0` and `rsp_*` stable for all 3 cycles.
  - Raising `rsp_ready_i` gives a same-cycle accept of the next request.
- Signed compare: req1 presents a=0xFFFFFFFF, b=1, op=0xB.
  - Response: `rsp_c_o=1`, `rsp_flag_o=1`.
  - The same operands with op=0x3 give 0/0.
- Illegal opcode: op=0xD.
  - With `ALU_ARB_OPCHECK_EN`: `rsp_err_o=1`, `rsp_c_o=0`.
  - Without it: `rsp_err_o=0`, `rsp_c_o=0`.
- Reset mid-stream: assert `rstn_i` while `rsp_valid_o=1`.
  - `rsp_valid_o` drops immediately (asynchronous) and `ptr` returns to 0.
  - The first grant after release goes to req0 when all requesters are valid.
